core_boot_sequencer: RTL
========================

Name: core_boot_sequencer

Overview:
Hardware replacement for the bench-driven boot flow of the vanilla core.
- Preloads data memory with image words via stores.
- Streams the INSTR, REG, BAR and PC network packets into the core, then issues NULL packets.
- Owns the data-memory port mux: the loader holds the port during boot, and the core gets it only after boot.
- Sits between the image ROMs, data_mem and core_flattened.

Parameters:
DATA_WORDS_P, 1024, data words preloaded
INSTR_WORDS_P, 1024, instruction packets sent
REG_WORDS_P, 64, register packets sent (2**rs_imm_size_gp)
BAR_MASK_P, 32'h2, barrier mask net_data
BAR_ADDR_P, 10'd24, barrier packet net_addr
START_PC_P, 32'h5, PC packet net_data
CORE_ID_P, 10'd1, ID field of every packet

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
start_i  in  1  begin boot; sampled in IDLE only
drom_addr_o  out  10  data-image ROM index
drom_data_i  in  32  data word; valid 1 cycle after address
irom_addr_o  out  10  instruction ROM index; 1-cycle latency
irom_data_i  in  16  {opcode[15:11],rd[10:6],rs_imm[5:0]}
rrom_addr_o  out  6  register ROM index; 1-cycle latency
rrom_data_i  in  40  [37:32] reg index, [31:0] value
core_mem_flat_i  in  $bits(mem_in_s)  core request
core_mem_addr_i  in  32  core address
mem_flat_o  out  $bits(mem_in_s)  to data_mem
mem_addr_o  out  32  to data_mem
packet_flat_o  out  $bits(net_packet_s)  registered packet to core
busy_o  out  1  boot in progress
done_o  out  1  in RUN

Behaviour:
- Reset (reset==0, sampled at posedge):
  - state=IDLE; all counters 0.
  - packet_flat_o=0 (net_op NULL).
  - mem_flat_o: valid=0, wen=0, yumi=0; mem_addr_o=0.
  - busy_o=0, done_o=0.
  - Reset asserted mid-operation aborts boot on that edge; memory contents already written are not undone.
- Port mux: mem_flat_o/mem_addr_o are driven by the loader in every state except RUN. In RUN they pass the core's signals through combinationally. In IDLE the loader drives valid=0.
- States:
  - IDLE: start_i=1 -> DMEM. busy_o=1 from the next cycle.
  - DMEM: two cycles per word.
    - Phase A: drive drom_addr_o=i.
    - Phase B: present a store with valid=1, yumi=1, wen=1, byte_not_word=0, mem_addr_o=i*4 (32-bit, no wrap), write_data=drom_data_i.
    - In phase A, valid=0.
    - After word DATA_WORDS_P-1 -> INSTR.
  - INSTR: pipelined, one packet per cycle.
    - Cycle k presents irom_addr_o=k. Packet k is registered on cycle k+1.
    - Packet fields: net_op=INSTR, reserved=0, net_data={16'b0,irom_data_i}, net_addr=k.
    - After packet INSTR_WORDS_P-1 -> REG.
  - REG: same pipelining.
    - Packet fields: net_op=REG, net_data=rrom_data_i[31:0], net_addr={4'b0,rrom_data_i[37:32]}.
    - After REG_WORDS_P packets -> BAR.
  - BAR: one packet with net_op=BAR, net_data=BAR_MASK_P, net_addr=BAR_ADDR_P -> PC.
  - PC: one packet with net_op=PC, net_data=START_PC_P, net_addr=0 -> RUN.
  - RUN: packet_flat_o holds net_op=NULL, net_data=32'hFFFF_FFFE, net_addr=BAR_ADDR_P. done_o=1, busy_o=0. Leaving RUN requires reset.
- Every packet's ID field is CORE_ID_P.
- No packet bubbles between the INSTR, REG, BAR and PC phases. The first REG packet immediately follows the last INSTR packet.
- start_i outside IDLE is ignored. start_i held high does not retrigger.
- Counters are sized $clog2(max)+1 and compared to parameters; no wrap occurs.
- Latency from start_i to done_o = 1 + 2*DATA_WORDS_P + 1 + INSTR_WORDS_P + REG_WORDS_P + 2 cycles.
  - The exact formula is fixed by RTL and is checked against the bench golden count.

Optional Feature:
BOOT_STATUS_MONITOR_EN
- Enabled: adds outputs fail_o, halt_o and pass_count_o[15:0], all reset to 0. In RUN, on a core request with valid=1:
  - core_mem_addr_i==32'hDEAD_DEAD sets sticky fail_o and halt_o.
  - 32'h600D_BEEF sets sticky halt_o.
  - 32'hC0FF_EEEE increments pass_count_o, saturating at 16'hFFFF.
- Disabled: these ports are absent and there is no monitor logic.

Decomposition:
- Shared package (definitions.sv): net_packet_s, mem_in_s, the net_op enum, instruction_s, rs_imm_size_gp, and a new boot_state_e enum (IDLE, DMEM, INSTR, REG, BAR, PC, RUN).
- One sub-module: boot_mem_arbiter. It is the registered loader-side driver plus the combinational select mux, with select=(state==RUN).

Test Plan:
- Reset mid-DMEM at word 5, then restart -> all outputs at reset values the next cycle; the rerun writes word 0 to address 0.
- DMEM=4 with ROM {1,2,3,4} -> stores at addresses 0,4,8,12 with data 1..4; valid never high in consecutive cycles.
- INSTR=3 with ROM {16'h0841,16'h1000,16'hFFFF} -> packets INSTR with net_addr 0,1,2 and net_data 32'h0000_0841, 32'h0000_1000, 32'h0000_FFFF on back-to-back cycles.
- REG entry 40'h05_1234_5678 -> REG packet with net_addr=5, net_data=32'h1234_5678; followed by BAR (2,24) then PC (5,0).
- In RUN, a core load from addr 32'h100 -> appears on mem_addr_o in the same cycle; packet stays NULL/FFFF_FFFE.
- Monitor enabled: core write to 32'hC0FF_EEEE twice, then 32'hDEAD_DEAD -> pass_count_o=2, fail_o=1, halt_o=1.

Source files
------------

// File: rtl/core_boot_sequencer_pkg.sv
// Shared types for the vanilla core boot path: network packet, data-memory request,
// instruction word layout and the boot sequencer state encoding.
package core_boot_sequencer_pkg;

  localparam int rs_imm_size_gp = 6;

  typedef enum logic [2:0] {
    NULL  = 3'd0,
    INSTR = 3'd1,
    REG   = 3'd2,
    PC    = 3'd3,
    BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [4:0]                opcode;
    logic [4:0]                rd;
    logic [rs_imm_size_gp-1:0] rs_imm;
  } instruction_s;

  typedef struct packed {
    logic [9:0]  ID;
    net_op_e     net_op;
    logic [4:0]  reserved;
    logic [9:0]  net_addr;
    logic [31:0] net_data;
  } net_packet_s;

  // valid is the MSB of the flattened request
  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef enum logic [2:0] {
    S_IDLE, S_DMEM, S_INSTR, S_REG, S_BAR, S_PC, S_RUN
  } boot_state_e;

  localparam int NET_PACKET_W = $bits(net_packet_s);
  localparam int MEM_IN_W     = $bits(mem_in_s);

endpackage

// File: rtl/core_boot_sequencer_mem_arbiter.sv
// Data-memory port owner: registered loader store driver plus a combinational
// select that hands the port to the core once boot has finished.
module boot_mem_arbiter
  import core_boot_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_store,
  input  logic [31:0]         ld_addr,
  input  logic [31:0]         ld_data,
  input  logic                sel_core,
  input  logic [MEM_IN_W-1:0] core_mem_flat,
  input  logic [31:0]         core_mem_addr,
  output logic [MEM_IN_W-1:0] mem_flat,
  output logic [31:0]         mem_addr
);

  logic        vld_p1;
  logic [31:0] addr_p1;
  mem_in_s     ld_req;

  always_ff @(posedge clk) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= ld_store;
  end

  always_ff @(posedge clk) begin
    addr_p1 <= ld_addr;
  end

  // ROM data arrives in the cycle the registered store is presented, so it bypasses the register
  always_comb begin
    ld_req            = '0;
    ld_req.valid      = vld_p1;
    ld_req.wen        = vld_p1;
    ld_req.yumi       = vld_p1;
    ld_req.write_data = vld_p1 ? ld_data : 32'h0;
    mem_flat          = ld_req;
    mem_addr          = vld_p1 ? addr_p1 : 32'h0;
    if (sel_core) begin
      mem_flat = core_mem_flat;
      mem_addr = core_mem_addr;
    end
  end

endmodule

// File: rtl/core_boot_sequencer.sv
// Boot sequencer for the vanilla core: preloads data memory, streams INSTR/REG/BAR/PC
// packets, then releases the memory port. Optional monitor: BOOT_STATUS_MONITOR_EN.
module core_boot_sequencer
  import core_boot_sequencer_pkg::*;
#(
  parameter int          DATA_WORDS_P  = 1024,
  parameter int          INSTR_WORDS_P = 1024,
  parameter int          REG_WORDS_P   = 64,
  parameter logic [31:0] BAR_MASK_P    = 32'h2,
  parameter logic [9:0]  BAR_ADDR_P    = 10'd24,
  parameter logic [31:0] START_PC_P    = 32'h5,
  parameter logic [9:0]  CORE_ID_P     = 10'd1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  output logic [9:0]              drom_addr_o,
  input  logic [31:0]             drom_data_i,
  output logic [9:0]              irom_addr_o,
  input  logic [15:0]             irom_data_i,
  output logic [5:0]              rrom_addr_o,
  input  logic [39:0]             rrom_data_i,
  input  logic [MEM_IN_W-1:0]     core_mem_flat_i,
  input  logic [31:0]             core_mem_addr_i,
  output logic [MEM_IN_W-1:0]     mem_flat_o,
  output logic [31:0]             mem_addr_o,
  output logic [NET_PACKET_W-1:0] packet_flat_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef BOOT_STATUS_MONITOR_EN
  ,
  output logic                    fail_o,
  output logic                    halt_o,
  output logic [15:0]             pass_count_o
`endif
);

  localparam int MAX_WORDS = (DATA_WORDS_P > INSTR_WORDS_P)
                           ? ((DATA_WORDS_P > REG_WORDS_P) ? DATA_WORDS_P : REG_WORDS_P)
                           : ((INSTR_WORDS_P > REG_WORDS_P) ? INSTR_WORDS_P : REG_WORDS_P);
  localparam int CNT_W = $clog2(MAX_WORDS) + 1;

  boot_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             phase_b, phase_b_nxt;
  logic [31:0]      cnt32;
  logic [9:0]       pkt_idx;
  logic [5:0]       rrom_next;
  net_packet_s      pkt_p0, pkt_p1;
  logic             unused_rrom_bits;

  assign cnt32            = 32'(cnt);
  assign pkt_idx          = cnt32[9:0] - 10'd1;
  assign rrom_next        = cnt32[5:0] + 6'd1;
  assign unused_rrom_bits = ^rrom_data_i[39:38];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      phase_b <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      phase_b <= phase_b_nxt;
    end
  end

  // INSTR spends one extra cycle draining the ROM pipeline; REG address 0 is issued in it
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    phase_b_nxt = phase_b;
    case (state)
      S_IDLE: if (start_i) begin
        state_nxt   = S_DMEM;
        cnt_nxt     = '0;
        phase_b_nxt = 1'b0;
      end
      S_DMEM: begin
        phase_b_nxt = ~phase_b;
        if (phase_b) begin
          if (cnt32 == 32'(DATA_WORDS_P - 1)) begin
            state_nxt = S_INSTR;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_INSTR: begin
        if (cnt32 == 32'(INSTR_WORDS_P)) begin
          state_nxt = S_REG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_REG: begin
        if (cnt32 == 32'(REG_WORDS_P - 1)) begin
          state_nxt = S_BAR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_BAR:   state_nxt = S_PC;
      S_PC:    state_nxt = S_RUN;
      default: state_nxt = state;
    endcase
  end

  assign drom_addr_o = (state == S_DMEM)  ? cnt32[9:0] : 10'd0;
  assign irom_addr_o = (state == S_INSTR) ? cnt32[9:0] : 10'd0;
  assign rrom_addr_o = (state == S_REG)   ? rrom_next  : 6'd0;

  always_comb begin
    pkt_p0 = pkt_p1;
    case (state)
      S_INSTR: if (cnt32 != 32'd0) begin
        pkt_p0          = '0;
        pkt_p0.ID       = CORE_ID_P;
        pkt_p0.net_op   = INSTR;
        pkt_p0.net_addr = pkt_idx;
        pkt_p0.net_data = {16'h0, irom_data_i};
      end
      S_REG: begin
        pkt_p0          = '0;
        pkt_p0.ID       = CORE_ID_P;
        pkt_p0.net_op   = REG;
        pkt_p0.net_addr = {4'h0, rrom_data_i[37:32]};
        pkt_p0.net_data = rrom_data_i[31:0];
      end
      S_BAR: begin
        pkt_p0          = '0;
        pkt_p0.ID       = CORE_ID_P;
        pkt_p0.net_op   = BAR;
        pkt_p0.net_addr = BAR_ADDR_P;
        pkt_p0.net_data = BAR_MASK_P;
      end
      S_PC: begin
        pkt_p0          = '0;
        pkt_p0.ID       = CORE_ID_P;
        pkt_p0.net_op   = PC;
        pkt_p0.net_data = START_PC_P;
      end
      S_RUN: begin
        pkt_p0          = '0;
        pkt_p0.ID       = CORE_ID_P;
        pkt_p0.net_op   = NULL;
        pkt_p0.net_addr = BAR_ADDR_P;
        pkt_p0.net_data = 32'hFFFF_FFFE;
      end
      default: pkt_p0 = pkt_p1;
    endcase
  end

  // ---- stage p1: registered packet to the core ----
  always_ff @(posedge clk) begin
    if (!reset) pkt_p1 <= '0;
    else        pkt_p1 <= pkt_p0;
  end

  assign packet_flat_o = pkt_p1;
  assign busy_o        = (state != S_IDLE) && (state != S_RUN);
  assign done_o        = (state == S_RUN);

  boot_mem_arbiter u_arb (
    .clk           (clk),
    .reset         (reset),
    .ld_store      ((state == S_DMEM) && !phase_b),
    .ld_addr       ({cnt32[29:0], 2'b00}),
    .ld_data       (drom_data_i),
    .sel_core      (state == S_RUN),
    .core_mem_flat (core_mem_flat_i),
    .core_mem_addr (core_mem_addr_i),
    .mem_flat      (mem_flat_o),
    .mem_addr      (mem_addr_o)
  );

`ifdef BOOT_STATUS_MONITOR_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic mon_vld_p0;
  assign mon_vld_p0 = (state == S_RUN) && core_mem_flat_i[MEM_IN_W-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      fail_o       <= 1'b0;
      halt_o       <= 1'b0;
      pass_count_o <= 16'h0;
    end else if (mon_vld_p0) begin
      if (core_mem_addr_i == 32'hDEAD_DEAD) begin
        fail_o <= 1'b1;
        halt_o <= 1'b1;
      end else if (core_mem_addr_i == 32'h600D_BEEF) begin
        halt_o <= 1'b1;
      end else if (core_mem_addr_i == 32'hC0FF_EEEE) begin
        pass_count_o <= sat_inc16(pass_count_o);
      end
    end
  end
`endif

endmodule
